// File: rtl/fb_pkg.sv
// Shared types and defaults for the double-buffered frame memory arbiter.
// Optional missed-deadline counter: FRAME_DROP_CNT_EN.
package fb_pkg;

  localparam int unsigned FB_W       = 640;
  localparam int unsigned FB_H       = 480;
  localparam int unsigned FB_ADDR_W  = 20;
  localparam int unsigned FB_COLOR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DRAWING,
    WAIT_VB,
    SWAP
  } fb_state_t;

  // Linear address b*W*H + y*W + x. The row term is built from shifts and adds only.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic b,
                                                   input logic [9:0] x,
                                                   input logic [9:0] y);
    logic [FB_ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FB_ADDR_W; i++) begin
      if (FB_W[i]) acc = acc + (FB_ADDR_W'(y) << i);
    end
    acc = acc + FB_ADDR_W'(x);
    if (b) acc = acc + FB_ADDR_W'(FB_W * FB_H);
    return acc;
  endfunction

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Single-port frame memory bus; the arbiter is the master.
interface frame_buffer_arbiter_if #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned COLOR_W = 8
) ();

  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_we;
  logic [COLOR_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Combinational frame address: buffer*W*H + y*W + x, using shift-adds for y*W.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int unsigned W      = FB_W,
  parameter int unsigned H      = FB_H,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic              buffer,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] FRAME = ADDR_W'(W * H);

  logic [ADDR_W-1:0] row;

  // W is a constant, so each set bit of W folds into one shifted copy of y.
  always_comb begin
    row = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (W[i]) row = row + (ADDR_W'(y) << i);
    end
    addr = row + ADDR_W'(x) + (buffer ? FRAME : '0);
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Time-slices the double-buffered frame memory between scan-out reads and engine writes,
// swapping buffers only at vsync. Define FRAME_DROP_CNT_EN to add the drop_count port.
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned W       = FB_W,
  parameter int unsigned H       = FB_H,
  parameter int unsigned ADDR_W  = FB_ADDR_W,
  parameter int unsigned COLOR_W = FB_COLOR_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               vs,
  input  logic               display_en,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         draw_x,
  input  logic [9:0]         draw_y,
  input  logic [COLOR_W-1:0] draw_color,
  input  logic               draw_valid,
  input  logic               draw_done,
  output logic               wr_en,
  output logic               buffer_using,
  output logic               frame_start,
  output logic [COLOR_W-1:0] pixel_color,
`ifdef FRAME_DROP_CNT_EN
  output logic [15:0]        drop_count,
`endif
  frame_buffer_arbiter_if.master mem
);

  fb_state_t         state;
  logic              phase;
  logic              vs_q;
  logic              vs_fall;
  logic              read_slot;
  logic              accept;
  logic              in_range;
  logic              rd_issue;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign vs_fall   = vs_q & ~vs;
  assign read_slot = ~phase & display_en;
  assign wr_en     = ~read_slot & (state == DRAWING);
  assign accept    = wr_en & draw_valid;
  assign in_range  = (32'(draw_x) < W) && (32'(draw_y) < H);

  fb_addr_gen #(.W(W), .H(H), .ADDR_W(ADDR_W)) u_rd_addr (
    .buffer (~buffer_using),
    .x      (DrawX),
    .y      (DrawY),
    .addr   (rd_addr)
  );

  fb_addr_gen #(.W(W), .H(H), .ADDR_W(ADDR_W)) u_wr_addr (
    .buffer (buffer_using),
    .x      (draw_x),
    .y      (draw_y),
    .addr   (wr_addr)
  );

  // rd_issue/rd_valid track a read through the one-cycle memory latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase         <= 1'b0;
      vs_q          <= 1'b0;
      rd_issue      <= 1'b0;
      rd_valid      <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_we    <= 1'b0;
      pixel_color   <= '0;
    end else begin
      phase    <= ~phase;
      vs_q     <= vs;
      rd_issue <= read_slot;
      rd_valid <= rd_issue;
      if (read_slot) begin
        mem.mem_addr <= rd_addr;
        mem.mem_we   <= 1'b0;
      end else if (accept) begin
        mem.mem_addr  <= wr_addr;
        mem.mem_wdata <= draw_color;
        mem.mem_we    <= in_range;
      end else begin
        mem.mem_we <= 1'b0;
      end
      if (rd_valid) begin
        pixel_color <= mem.mem_rdata;
      end else if (!display_en) begin
        pixel_color <= '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      frame_start  <= 1'b0;
      buffer_using <= 1'b0;
`ifdef FRAME_DROP_CNT_EN
      drop_count   <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_fall) begin
            state       <= START;
            frame_start <= 1'b1;
          end
        end
        START: state <= DRAWING;
        DRAWING: begin
          // draw_done wins over a coincident vs_fall; the swap waits a frame.
          if (draw_done) begin
            state <= WAIT_VB;
          end else if (vs_fall) begin
`ifdef FRAME_DROP_CNT_EN
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
          end
        end
        WAIT_VB: begin
          if (vs_fall) state <= SWAP;
        end
        SWAP: begin
          buffer_using <= ~buffer_using;
          state        <= START;
          frame_start  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Scoreboard bench for frame_buffer_arbiter: writes and frame_start pulses are checked by
// monitors against queued expectations; other checks are directed.
module tb_frame_buffer_arbiter;
  import fb_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       vs;
  logic       display_en;
  logic [9:0] DrawX, DrawY, draw_x, draw_y;
  logic [7:0] draw_color;
  logic       draw_valid;
  logic       draw_done;
  logic       wr_en;
  logic       buffer_using;
  logic       frame_start;
  logic [7:0] pixel_color;
`ifdef FRAME_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  frame_buffer_arbiter_if mem_bus ();

  frame_buffer_arbiter dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .vs           (vs),
    .display_en   (display_en),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .draw_color   (draw_color),
    .draw_valid   (draw_valid),
    .draw_done    (draw_done),
    .wr_en        (wr_en),
    .buffer_using (buffer_using),
    .frame_start  (frame_start),
    .pixel_color  (pixel_color),
`ifdef FRAME_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .mem          (mem_bus)
  );

  int checks = 0;
  int errors = 0;
  logic [27:0] wr_q[$];
  logic        fs_q[$];
  logic        fs_prev = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: registered read, data is a fixed function of the address.
  always @(posedge Clk) mem_bus.mem_rdata <= mem_bus.mem_addr[7:0] ^ 8'h5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset && mem_bus.mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none", mem_bus.mem_addr, mem_bus.mem_wdata);
      end else begin
        logic [27:0] e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(mem_bus.mem_addr), 32'(e[27:8]));
        check("wr_data", 32'(mem_bus.mem_wdata), 32'(e[7:0]));
      end
    end
  end

  always @(negedge Clk) begin
    if (fs_prev) check("fs_width", 32'(frame_start), 32'd0);
    if (frame_start === 1'b1) begin
      if (fs_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_start: got pulse expected none at %0t", $time);
      end else begin
        check("fs_buffer", 32'(buffer_using), 32'(fs_q.pop_front()));
      end
    end
    fs_prev = frame_start;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_wr(input logic want);
    int n = 0;
    while (wr_en !== want && n < 16) begin
      tick();
      n++;
    end
    if (wr_en !== want) begin
      checks++;
      errors++;
      $display("FAIL wait_wr_timeout: got wr_en %0b expected %0b", wr_en, want);
    end
  endtask

  task automatic do_write(input logic [9:0] x, input logic [9:0] y, input logic [7:0] c,
                          input logic [19:0] exp_addr, input logic keep);
    wait_wr(1'b1);
    draw_x = x;
    draw_y = y;
    draw_color = c;
    draw_valid = 1'b1;
    if (keep) wr_q.push_back({exp_addr, c});
    tick();
    draw_valid = 1'b0;
    if (!keep) begin
      @(negedge Clk);
      check("clip_we", 32'(mem_bus.mem_we), 32'd0);
    end
  endtask

  task automatic vs_pulse();
    vs = 1'b0;
    tick();
    tick();
    vs = 1'b1;
    tick();
  endtask

  task automatic read_addr(input logic [19:0] exp);
    wait_wr(1'b0);
    tick();
    @(negedge Clk);
    check("rd_addr", 32'(mem_bus.mem_addr), 32'(exp));
    check("rd_we", 32'(mem_bus.mem_we), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    Reset = 1'b1; vs = 1'b1; display_en = 1'b0;
    DrawX = '0; DrawY = '0; draw_x = '0; draw_y = '0; draw_color = '0;
    draw_valid = 1'b0; draw_done = 1'b0;
    repeat (3) tick();
    @(negedge Clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_buf", 32'(buffer_using), 32'd0);
    check("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_bus.mem_wdata), 32'd0);
    check("rst_pixel", 32'(pixel_color), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
`ifdef FRAME_DROP_CNT_EN
    check("rst_drop", 32'(drop_count), 32'd0);
`endif
    Reset = 1'b0;
    repeat (3) tick();
    check("idle_wr_en", 32'(wr_en), 32'd0);

    // First frame
    fs_q.push_back(1'b0);
    vs_pulse();
    check("state_drawing", 32'(dut.state), 32'(DRAWING));
    check("buf_first", 32'(buffer_using), 32'd0);
    check("wr_en_blank", 32'(wr_en), 32'd1);
    tick();
    check("wr_en_blank2", 32'(wr_en), 32'd1);

    // Scan-out reads from the front buffer (1 while drawing 0)
    display_en = 1'b1; DrawX = 10'd5; DrawY = 10'd2;
    a = wr_en;
    tick();
    check("wr_en_alt", 32'(a ^ wr_en), 32'd1);
    read_addr(20'd308485);
    repeat (4) tick();
    check("pixel_5_2", 32'(pixel_color), 32'h5F);
    wait_wr(1'b0);
    DrawX = 10'd6;
    tick();
    @(negedge Clk);
    check("rd_addr_6", 32'(mem_bus.mem_addr), 32'd308486);
    tick();
    @(negedge Clk);
    check("pixel_latency_hold", 32'(pixel_color), 32'h5F);
    tick();
    @(negedge Clk);
    check("pixel_6_2", 32'(pixel_color), 32'h5C);
    display_en = 1'b0;
    repeat (3) tick();
    check("pixel_blank", 32'(pixel_color), 32'd0);

    // Writes to back buffer 0, including clipping
    do_write(10'd639, 10'd479, 8'hA7, 20'd307199, 1'b1);
    do_write(10'd640, 10'd0,   8'h11, 20'd0,      1'b0);
    do_write(10'd3,   10'd1,   8'h3C, 20'd643,    1'b1);
    do_write(10'd0,   10'd480, 8'h22, 20'd0,      1'b0);

    // Completed frame then vsync: swap to 1
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    check("state_wait_vb", 32'(dut.state), 32'(WAIT_VB));
    fs_q.push_back(1'b1);
    vs_pulse();
    check("buf_swapped", 32'(buffer_using), 32'd1);
    check("state_drawing2", 32'(dut.state), 32'(DRAWING));
    display_en = 1'b1; DrawX = 10'd5; DrawY = 10'd2;
    read_addr(20'd1285);
    display_en = 1'b0;
    do_write(10'd0,   10'd0,   8'h77, 20'd307200, 1'b1);
    do_write(10'd639, 10'd479, 8'h99, 20'd614399, 1'b1);

    // vs_fall and draw_done together: no swap until the next vsync
    vs = 1'b0; draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    check("coinc_state", 32'(dut.state), 32'(WAIT_VB));
    tick();
    vs = 1'b1;
    repeat (2) tick();
    check("coinc_buf", 32'(buffer_using), 32'd1);
`ifdef FRAME_DROP_CNT_EN
    check("coinc_drop", 32'(drop_count), 32'd0);
`endif
    fs_q.push_back(1'b0);
    vs_pulse();
    check("buf_back0", 32'(buffer_using), 32'd0);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    fs_q.push_back(1'b1);
    vs_pulse();
    check("buf_again1", 32'(buffer_using), 32'd1);

    // Missed deadline
    vs_pulse();
    check("miss_state", 32'(dut.state), 32'(DRAWING));
    check("miss_buf", 32'(buffer_using), 32'd1);
`ifdef FRAME_DROP_CNT_EN
    check("miss_drop", 32'(drop_count), 32'd1);
`endif

    // Reset during DRAWING with a write in flight
    wait_wr(1'b1);
    draw_x = 10'd1; draw_y = 10'd1; draw_color = 8'hEE; draw_valid = 1'b1;
    Reset = 1'b1;
    tick();
    draw_valid = 1'b0;
    @(negedge Clk);
    check("mid_rst_we", 32'(mem_bus.mem_we), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_buf", 32'(buffer_using), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    check("mid_rst_pixel", 32'(pixel_color), 32'd0);
`ifdef FRAME_DROP_CNT_EN
    check("mid_rst_drop", 32'(drop_count), 32'd0);
`endif
    Reset = 1'b0;
    repeat (3) tick();

    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("fs_q_drained", 32'(fs_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
